down_counter60: RTL and testbench

DOWN_COUNTER60 -- requirements
Module: down_counter60

---
 rtl/down_counter60.sv | 79 +++++++
 tb/tb_down_counter60.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/down_counter60.sv
// BCD down-counter over 59..00 (tens 0-5, ones 0-9) with parallel load and cascadable borrow.
// WRAP=1 rolls 00 -> 59 with a borrow pulse; WRAP=0 stops at 00 and raises a sticky DONE.
module down_counter60 #(
    parameter int unsigned WRAP = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] LD10,
    input  logic [2:0] LD6,
    input  logic       en,
    output logic [3:0] CNT10,
    output logic [2:0] CNT6,
    output logic       BOR,
    output logic       ZERO,
    output logic       DONE
);

    localparam bit WrapEn = (WRAP != 0);

    typedef enum logic {StRun, StExpired} state_e;

    state_e     state_q;
    logic [3:0] cnt10_q;
    logic [2:0] cnt6_q;
    logic       done_q;

    logic [3:0] ld10_sat;
    logic [2:0] ld6_sat;
    logic       is_zero;
    logic       dec;

    always_comb begin
        ld10_sat = (LD10 > 4'd9) ? 4'd9 : LD10;
        ld6_sat  = (LD6 > 3'd5) ? 3'd5 : LD6;
        is_zero  = (cnt10_q == 4'd0) && (cnt6_q == 3'd0);
        dec      = en && !load && (state_q == StRun);
    end

    // Borrow is combinational so a following stage decrements on the same edge.
    assign BOR   = dec && !rst && is_zero && WrapEn;
    assign ZERO  = is_zero;
    assign CNT10 = cnt10_q;
    assign CNT6  = cnt6_q;
    assign DONE  = done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            cnt10_q <= 4'd0;
            cnt6_q  <= 3'd0;
            done_q  <= 1'b0;
        end else if (load) begin
            state_q <= StRun;
            cnt10_q <= ld10_sat;
            cnt6_q  <= ld6_sat;
            done_q  <= 1'b0;
        end else if (dec) begin
            if (cnt10_q != 4'd0) begin
                cnt10_q <= cnt10_q - 4'd1;
                if (!WrapEn && (cnt6_q == 3'd0) && (cnt10_q == 4'd1)) begin
                    state_q <= StExpired;
                    done_q  <= 1'b1;
                end
            end else if (cnt6_q != 3'd0) begin
                cnt10_q <= 4'd9;
                cnt6_q  <= cnt6_q - 3'd1;
            end else if (WrapEn) begin
                cnt10_q <= 4'd9;
                cnt6_q  <= 3'd5;
            end else begin
                // Already at 00 with no wrap: expire in place.
                state_q <= StExpired;
                done_q  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_down_counter60.sv
// Directed bench: a wrapping seconds stage cascaded into a minutes stage, plus a
// separate non-wrapping stage; expected values are hand-computed constants.
module tb_down_counter60;

    logic       clk;
    logic       rst;
    logic       ld_s, en_s, ld_m, ld_z, en_z;
    logic [3:0] ld10_s, ld10_m, ld10_z;
    logic [2:0] ld6_s, ld6_m, ld6_z;
    logic [3:0] cnt10_s, cnt10_m, cnt10_z;
    logic [2:0] cnt6_s, cnt6_m, cnt6_z;
    logic       bor_s, bor_m, bor_z;
    logic       zero_s, zero_m, zero_z;
    logic       done_s, done_m, done_z;

    int n_vec;
    int n_err;
    int exp_val;
    int bor_cnt;

    down_counter60 #(.WRAP(1)) u_sec (
        .clk(clk), .rst(rst), .load(ld_s), .LD10(ld10_s), .LD6(ld6_s), .en(en_s),
        .CNT10(cnt10_s), .CNT6(cnt6_s), .BOR(bor_s), .ZERO(zero_s), .DONE(done_s)
    );

    down_counter60 #(.WRAP(1)) u_min (
        .clk(clk), .rst(rst), .load(ld_m), .LD10(ld10_m), .LD6(ld6_m), .en(bor_s),
        .CNT10(cnt10_m), .CNT6(cnt6_m), .BOR(bor_m), .ZERO(zero_m), .DONE(done_m)
    );

    down_counter60 #(.WRAP(0)) u_nowrap (
        .clk(clk), .rst(rst), .load(ld_z), .LD10(ld10_z), .LD6(ld6_z), .en(en_z),
        .CNT10(cnt10_z), .CNT6(cnt6_z), .BOR(bor_z), .ZERO(zero_z), .DONE(done_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int sec_val();
        return int'(cnt6_s) * 10 + int'(cnt10_s);
    endfunction

    function automatic int nw_val();
        return int'(cnt6_z) * 10 + int'(cnt10_z);
    endfunction

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        ld_s = 1'b0; en_s = 1'b0; ld10_s = 4'd0; ld6_s = 3'd0;
        ld_m = 1'b0; ld10_m = 4'd0; ld6_m = 3'd0;
        ld_z = 1'b0; en_z = 1'b0; ld10_z = 4'd0; ld6_z = 3'd0;

        // Reset state; BOR suppressed while rst high even with en at 00.
        step();
        en_s = 1'b1;
        #1;
        check_eq("rst_cnt", sec_val(), 0);
        check_eq("rst_zero", int'(zero_s), 1);
        check_eq("rst_done", int'(done_z), 0);
        check_eq("rst_bor", int'(bor_s), 0);

        // Free run with en=1 from reset exit: 00 -> 59 -> ... -> 00 -> 59 ...
        rst = 1'b0;
        exp_val = 0;
        bor_cnt = 0;
        for (int i = 0; i < 120; i++) begin
            #1;
            check_eq("run_bor", int'(bor_s), (exp_val == 0) ? 1 : 0);
            if (bor_s) bor_cnt++;
            step();
            exp_val = (exp_val == 0) ? 59 : exp_val - 1;
            check_eq("run_cnt", sec_val(), exp_val);
        end
        check_eq("run_bor_count", bor_cnt, 2);

        // Hold with en=0.
        en_s = 1'b0;
        #1;
        check_eq("hold_bor", int'(bor_s), 0);
        step();
        check_eq("hold_cnt", sec_val(), 0);

        // Saturating load, with en in the same cycle: load wins, no borrow.
        ld_s = 1'b1; ld10_s = 4'hC; ld6_s = 3'h7; en_s = 1'b1;
        #1;
        check_eq("ld_en_bor", int'(bor_s), 0);
        step();
        check_eq("ld_sat_ones", int'(cnt10_s), 9);
        check_eq("ld_sat_tens", int'(cnt6_s), 5);

        // Load 10 and pulse en: tens borrow, down to 00, then wrap with BOR.
        ld10_s = 4'd0; ld6_s = 3'd1; en_s = 1'b0;
        step();
        ld_s = 1'b0;
        check_eq("ld10_cnt", sec_val(), 10);
        for (int k = 1; k <= 11; k++) begin
            en_s = 1'b1;
            #1;
            check_eq("pulse_bor", int'(bor_s), (k == 11) ? 1 : 0);
            step();
            en_s = 1'b0;
            check_eq("pulse_cnt", sec_val(), (k == 11) ? 59 : 10 - k);
            step();
        end

        // WRAP=0: load 02, count to 00, expire, hold, then reload 30.
        ld_z = 1'b1; ld10_z = 4'd2; ld6_z = 3'd0;
        step();
        ld_z = 1'b0; en_z = 1'b1;
        check_eq("nw_ld02", nw_val(), 2);
        step();
        check_eq("nw_01", nw_val(), 1);
        check_eq("nw_01_done", int'(done_z), 0);
        step();
        check_eq("nw_00", nw_val(), 0);
        check_eq("nw_00_done", int'(done_z), 1);
        for (int j = 0; j < 3; j++) begin
            #1;
            check_eq("nw_exp_bor", int'(bor_z), 0);
            step();
            check_eq("nw_exp_cnt", nw_val(), 0);
            check_eq("nw_exp_done", int'(done_z), 1);
        end
        ld_z = 1'b1; ld10_z = 4'd0; ld6_z = 3'd3;
        step();
        ld_z = 1'b0;
        check_eq("nw_ld30", nw_val(), 30);
        check_eq("nw_ld30_done", int'(done_z), 0);
        step();
        check_eq("nw_29", nw_val(), 29);

        // WRAP=0: load 00 then en -> stays 00, DONE next edge.
        en_z = 1'b0; ld_z = 1'b1; ld6_z = 3'd0; ld10_z = 4'd0;
        step();
        ld_z = 1'b0;
        check_eq("nw_ld00", nw_val(), 0);
        check_eq("nw_ld00_done", int'(done_z), 0);
        en_z = 1'b1;
        #1;
        check_eq("nw_ld00_bor", int'(bor_z), 0);
        step();
        check_eq("nw_ld00_en", nw_val(), 0);
        check_eq("nw_ld00_done1", int'(done_z), 1);

        // Cascade: seconds borrow drives minutes enable; load 01:00.
        ld_s = 1'b1; ld10_s = 4'd0; ld6_s = 3'd0; en_s = 1'b0;
        ld_m = 1'b1; ld10_m = 4'd1; ld6_m = 3'd0;
        step();
        ld_s = 1'b0; ld_m = 1'b0;
        check_eq("cas_ld_min", int'(cnt6_m) * 10 + int'(cnt10_m), 1);
        check_eq("cas_ld_sec", sec_val(), 0);
        en_s = 1'b1;
        step();
        check_eq("cas_first_min", int'(cnt6_m) * 10 + int'(cnt10_m), 0);
        check_eq("cas_first_sec", sec_val(), 59);
        for (int i = 0; i < 59; i++) step();
        check_eq("cas60_min", int'(cnt6_m) * 10 + int'(cnt10_m), 0);
        check_eq("cas60_sec", sec_val(), 0);
        for (int i = 0; i < 23; i++) step();
        check_eq("cas_37_sec", sec_val(), 37);
        check_eq("cas_37_min", int'(cnt6_m) * 10 + int'(cnt10_m), 59);

        // Reset mid-count with en still high; also clears the expired WRAP=0 stage.
        rst = 1'b1;
        step();
        check_eq("rst_mid_sec", sec_val(), 0);
        check_eq("rst_mid_min", int'(cnt6_m) * 10 + int'(cnt10_m), 0);
        check_eq("rst_mid_done", int'(done_z), 0);
        check_eq("rst_mid_bor", int'(bor_s), 0);
        rst = 1'b0;
        step();
        check_eq("post_rst_sec", sec_val(), 59);
        check_eq("post_rst_nw_done", int'(done_z), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
